vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter VRAM_AW, default 16: VRAM word-address width.
REQ-002 Parameter FIFO_DEPTH, default 4: display prefetch FIFO depth in words; power of two, minimum 2.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 clrn  in  1  reset, asynchronous, active-low.
REQ-005 cpu_addr  in  32  CPU byte address; only bits [VRAM_AW+1:2] are used.
REQ-006 cpu_wdata  in  32  CPU write data.
REQ-007 cpu_wr  in  4  CPU byte write enables (video_memory_write).
REQ-008 cpu_rd  in  1  CPU read request (video_memory_read).
REQ-009 cpu_rdata  out  32  CPU read data; valid in the cycle cpu_stall falls after a read.
REQ-010 cpu_stall  out  1  CPU must hold its request and freeze its PC while this is high.
REQ-011 disp_start  in  1  pulse that starts a display line fetch.
REQ-012 disp_base  in  VRAM_AW  first word address of the line; sampled on disp_start.
REQ-013 disp_len  in  10  number of words to fetch; sampled on disp_start; 0 means no fetch.
REQ-014 disp_pop  in  1  display consumes the FIFO head.
REQ-015 disp_data  out  32  FIFO head word.
REQ-016 disp_empty  out  1  FIFO empty.
REQ-017 disp_underflow  out  1  sticky flag: disp_pop was asserted while the FIFO was empty.
REQ-018 vram_addr  out  VRAM_AW  VRAM word address.
REQ-019 vram_wdata  out  32  VRAM write data.
REQ-020 vram_we  out  4  VRAM byte write enables.
REQ-021 vram_re  out  1  VRAM read strobe; the data arrives on vram_rdata in the next cycle.
REQ-022 vram_rdata  in  32  VRAM read data.

Function
REQ-023 FSM states: IDLE, CPU_RD (waiting for CPU read data), DISP_RD (waiting for display read data); at most one VRAM access is in flight.
REQ-024 A CPU request exists when |cpu_wr or cpu_rd; if both are set, the write takes priority and the read is ignored.
REQ-025 A display fetch is eligible when remaining>0 and fifo_count+inflight<FIFO_DEPTH.
REQ-026 A display fetch is urgent when it is eligible and fifo_count<=1.
REQ-027 Grant priority in IDLE: urgent display fetch first, then CPU request, then eligible display fetch; no VRAM access is issued in CPU_RD or DISP_RD.
REQ-028 CPU write grant: in the same cycle, drive vram_we=cpu_wr, vram_addr and vram_wdata, hold cpu_stall=0, and stay in IDLE; the write takes one cycle.
REQ-029 CPU read grant: drive vram_re=1 with cpu_stall=1 and go to CPU_RD.
REQ-030 In CPU_RD: cpu_rdata=vram_rdata, cpu_stall=0, then go to IDLE; the read takes two cycles.
REQ-031 cpu_stall=1 whenever a CPU request exists and is not completing in that cycle; otherwise cpu_stall=0.
REQ-032 Display fetch grant: drive vram_re=1 with vram_addr=fetch pointer, increment the fetch pointer (wrapping modulo 2^VRAM_AW), decrement remaining, set inflight, and go to DISP_RD.
REQ-033 In DISP_RD: push vram_rdata into the FIFO, clear inflight, and go to IDLE.
REQ-034 disp_start loads the fetch pointer with disp_base and remaining with disp_len, and flushes the FIFO.
REQ-035 If disp_start occurs while in DISP_RD, the returning word is discarded.
REQ-036 disp_start clears disp_underflow.
REQ-037 A pop on an empty FIFO is ignored and sets disp_underflow.
REQ-038 A simultaneous push and pop leaves fifo_count unchanged.
REQ-039 The FIFO is never pushed while full; the space check in REQ-025 guarantees this.
REQ-040 Outside a grant cycle: vram_we=0, vram_re=0, and vram_addr/vram_wdata hold their last values.
REQ-041 cpu_rdata is registered-free: it is driven combinationally from vram_rdata in CPU_RD and is 0 otherwise.

Reset
REQ-042 While clrn=0, regardless of clk:
- state=IDLE; fetch pointer=0; remaining=0; inflight=0; FIFO empty.
- disp_underflow=0.
- vram_we=0, vram_re=0, vram_addr=0, vram_wdata=0.
- disp_empty=1, disp_data=0, cpu_rdata=0.
- cpu_stall follows REQ-031.
REQ-043 Asserting reset mid-access abandons the in-flight access; no FIFO push occurs after reset is released.

Structure
REQ-044 Shared package vram_arb_pkg holds the FSM state encoding (IDLE=2'd0, CPU_RD=2'd1, DISP_RD=2'd2) and the default VRAM_AW and FIFO_DEPTH constants.
REQ-045 One sub-module, disp_fifo: a synchronous FIFO with push, pop, count, empty and full, clocked by clk with reset clrn.

Verification
REQ-046 CPU write alone: cpu_wr=4'b0011, cpu_addr=0xC0000010 -> in the same cycle vram_we=4'b0011, vram_addr=4, cpu_stall=0.
REQ-047 CPU read alone: cpu_rd=1, vram_rdata=0xDEADBEEF one cycle after vram_re -> cpu_stall=1 then 0, and cpu_rdata=0xDEADBEEF in the second cycle.
REQ-048 Display fill: disp_start with base=0x100, len=6, no pops -> fetches 0x100..0x103 and then stops with the FIFO full (4); after 2 pops it fetches 0x104 and 0x105, and remaining=0.
REQ-049 Contention: FIFO count=1 with a CPU read pending -> the display fetch is granted first and the CPU is stalled 4 cycles total; with count=3, the CPU is granted first.
REQ-050 Restart while in DISP_RD: disp_start during DISP_RD -> the returned word is not pushed, the FIFO is empty, and the next fetch uses the new base.
REQ-051 Underflow and reset: disp_pop while empty -> disp_underflow=1 until the next disp_start; clrn pulsed low during CPU_RD -> state=IDLE and all outputs at their REQ-042 values.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: FSM encoding, grant kinds and
// default geometry constants.
package vram_arb_pkg;

    localparam int DEF_VRAM_AW    = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        DISP_RD = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_CPU_WR = 2'd1,
        GNT_CPU_RD = 2'd2,
        GNT_DISP   = 2'd3
    } arb_grant_t;

endpackage

// File: rtl/vram_arbiter_disp_fifo.sv
// Display prefetch FIFO: single-clock circular buffer with flush, occupancy
// count, empty and full. The head reads as zero while the FIFO is empty.
module disp_fifo
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? {DW{1'b0}} : r_mem[r_rptr];

    // Storage array; contents are don't-care until written, head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between a stalling CPU port and a display line
// prefetcher feeding a small FIFO; at most one VRAM access is in flight.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int VRAM_AW    = DEF_VRAM_AW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic [3:0]         cpu_wr,
    input  logic               cpu_rd,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_stall,
    input  logic               disp_start,
    input  logic [VRAM_AW-1:0] disp_base,
    input  logic [9:0]         disp_len,
    input  logic               disp_pop,
    output logic [31:0]        disp_data,
    output logic               disp_empty,
    output logic               disp_underflow,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_wdata,
    output logic [3:0]         vram_we,
    output logic               vram_re,
    input  logic [31:0]        vram_rdata
);

    localparam int                 CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [VRAM_AW-1:0] FPTR_STEP = VRAM_AW'(1'b1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    arb_grant_t         w_gnt;
    logic [VRAM_AW-1:0] r_fptr;
    logic [9:0]         r_remain;
    logic               r_inflight;
    logic               r_underflow;
    logic [VRAM_AW-1:0] r_addr_last;
    logic [31:0]        r_wdata_last;

    logic               w_cpu_wr_req;
    logic               w_cpu_req;
    logic [VRAM_AW-1:0] w_cpu_word;
    logic [CW-1:0]      w_fifo_count;
    logic [CW-1:0]      w_occupancy;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_fifo_push;
    logic               w_disp_elig;
    logic               w_disp_urgent;
    logic               w_unused;

    assign w_cpu_wr_req = |cpu_wr;
    assign w_cpu_req    = w_cpu_wr_req || cpu_rd;
    assign w_cpu_word   = cpu_addr[VRAM_AW+1:2];
    assign w_unused     = ^{cpu_addr[31:VRAM_AW+2], cpu_addr[1:0], w_fifo_full};

    // A fetch is only eligible once the line is loaded, so a restart cycle never fetches.
    assign w_occupancy   = w_fifo_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_disp_elig   = (r_remain != 10'd0) && (w_occupancy < CW'(FIFO_DEPTH)) && !disp_start;
    assign w_disp_urgent = w_disp_elig && (w_fifo_count <= CW'(1'b1));

    // Grant selection in IDLE and next-state decode.
    always_comb begin
        w_gnt       = GNT_NONE;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!clrn) begin
                    w_gnt = GNT_NONE;
                end else if (w_disp_urgent) begin
                    w_gnt = GNT_DISP;
                end else if (w_cpu_req) begin
                    if (w_cpu_wr_req) begin
                        w_gnt = GNT_CPU_WR;
                    end else begin
                        w_gnt = GNT_CPU_RD;
                    end
                end else if (w_disp_elig) begin
                    w_gnt = GNT_DISP;
                end else begin
                    w_gnt = GNT_NONE;
                end
                case (w_gnt)
                    GNT_CPU_RD: w_state_nxt = CPU_RD;
                    GNT_DISP:   w_state_nxt = DISP_RD;
                    default:    w_state_nxt = IDLE;
                endcase
            end
            CPU_RD:  w_state_nxt = IDLE;
            DISP_RD: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // VRAM port drive; address and write data hold their last values between grants.
    always_comb begin
        vram_we    = 4'b0000;
        vram_re    = 1'b0;
        vram_addr  = r_addr_last;
        vram_wdata = r_wdata_last;
        case (w_gnt)
            GNT_CPU_WR: begin
                vram_we    = cpu_wr;
                vram_addr  = w_cpu_word;
                vram_wdata = cpu_wdata;
            end
            GNT_CPU_RD: begin
                vram_re   = 1'b1;
                vram_addr = w_cpu_word;
            end
            GNT_DISP: begin
                vram_re   = 1'b1;
                vram_addr = r_fptr;
            end
            default: begin
                vram_re = 1'b0;
            end
        endcase
    end

    assign cpu_stall      = w_cpu_req && !((r_state == CPU_RD) || (w_gnt == GNT_CPU_WR));
    assign cpu_rdata      = (r_state == CPU_RD) ? vram_rdata : 32'h0000_0000;
    assign disp_underflow = r_underflow;
    assign w_fifo_push    = (r_state == DISP_RD) && !disp_start;

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last driven VRAM address/data, replayed on idle cycles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_addr_last  <= {VRAM_AW{1'b0}};
            r_wdata_last <= 32'h0000_0000;
        end else begin
            r_addr_last  <= vram_addr;
            r_wdata_last <= vram_wdata;
        end
    end

    // Display line fetch pointer, remaining word count and in-flight flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_fptr     <= {VRAM_AW{1'b0}};
            r_remain   <= 10'd0;
            r_inflight <= 1'b0;
        end else begin
            if (disp_start) begin
                r_fptr   <= disp_base;
                r_remain <= disp_len;
            end else if (w_gnt == GNT_DISP) begin
                r_fptr   <= r_fptr + FPTR_STEP;
                r_remain <= r_remain - 10'd1;
            end
            if (w_gnt == GNT_DISP) begin
                r_inflight <= 1'b1;
            end else if (r_state == DISP_RD) begin
                r_inflight <= 1'b0;
            end
        end
    end

    // Sticky underflow flag; a new line clears it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_underflow <= 1'b0;
        end else if (disp_start) begin
            r_underflow <= 1'b0;
        end else if (disp_pop && w_fifo_empty) begin
            r_underflow <= 1'b1;
        end
    end

    disp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (32),
        .CW    (CW)
    ) u_disp_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_flush (disp_start),
        .i_push  (w_fifo_push),
        .i_wdata (vram_rdata),
        .i_pop   (disp_pop),
        .o_rdata (disp_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign disp_empty = w_fifo_empty;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model and a behavioural VRAM.
module tb_vram_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wr;
    logic        cpu_rd, cpu_stall;
    logic        disp_start, disp_pop, disp_empty, disp_underflow;
    logic [15:0] disp_base;
    logic [9:0]  disp_len;
    logic [31:0] disp_data;
    logic [15:0] vram_addr;
    logic [31:0] vram_wdata, vram_rdata;
    logic [3:0]  vram_we;
    logic        vram_re;

    always #5 clk = ~clk;

    vram_arbiter #(.VRAM_AW(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .disp_start(disp_start), .disp_base(disp_base), .disp_len(disp_len), .disp_pop(disp_pop),
        .disp_data(disp_data), .disp_empty(disp_empty), .disp_underflow(disp_underflow),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
        .vram_rdata(vram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tb_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural VRAM: unwritten words read as a pattern of their address.
    logic [31:0] vmem [logic [15:0]];
    logic [31:0] pend_rdata;

    function automatic logic [31:0] vinit(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    function automatic logic [31:0] vread(input logic [15:0] a);
        if (vmem.exists(a)) return vmem[a];
        return vinit(a);
    endfunction

    // Reference model: mode 0 free, 1 awaiting CPU read data, 2 awaiting display data.
    int          m_mode;
    logic [15:0] m_ptr;
    int          m_rem;
    logic [31:0] m_fifo [$];
    logic        m_under;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;

    logic [3:0]  s_we;
    logic        s_re, s_stall, s_empty, s_under;
    logic [15:0] s_addr;
    logic [31:0] s_rdata, s_data;
    logic [15:0] fetch_q [$];

    task automatic model_reset();
        m_mode = 0; m_ptr = 16'h0000; m_rem = 0; m_fifo.delete();
        m_under = 1'b0; m_addr = 16'h0000; m_wdata = 32'h0;
    endtask

    task automatic cycle(input logic [3:0] wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic st, input logic [15:0] base,
                         input logic [9:0] len, input logic pop);
        bit          cpu_req, disp_ok, urgent;
        int          gnt;
        logic [3:0]  e_we;
        logic        e_re, e_stall;
        logic [15:0] e_addr;
        logic [31:0] e_wdata, e_rdata, e_data, wv;
        @(negedge clk);
        cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_wdata = wd;
        disp_start = st; disp_base = base; disp_len = len; disp_pop = pop;
        vram_rdata = pend_rdata;
        #1;
        cpu_req = (wr != 4'd0) || rd;
        disp_ok = (m_mode == 0) && (m_rem > 0) && (m_fifo.size() < DEPTH) && !st;
        urgent  = disp_ok && (m_fifo.size() <= 1);
        gnt = 0;
        if (m_mode == 0) begin
            if (urgent) gnt = 3;
            else if (cpu_req) gnt = (wr != 4'd0) ? 1 : 2;
            else if (disp_ok) gnt = 3;
        end
        e_we    = (gnt == 1) ? wr : 4'd0;
        e_re    = (gnt >= 2);
        e_addr  = (gnt == 3) ? m_ptr : ((gnt == 1 || gnt == 2) ? addr[17:2] : m_addr);
        e_wdata = (gnt == 1) ? wd : m_wdata;
        e_stall = cpu_req && !((m_mode == 1) || (gnt == 1));
        e_rdata = (m_mode == 1) ? vram_rdata : 32'd0;
        e_data  = (m_fifo.size() != 0) ? m_fifo[0] : 32'd0;
        tb_check("vram_we", vram_we, e_we);
        tb_check("vram_re", vram_re, e_re);
        tb_check("vram_addr", vram_addr, e_addr);
        tb_check("vram_wdata", vram_wdata, e_wdata);
        tb_check("cpu_stall", cpu_stall, e_stall);
        tb_check("cpu_rdata", cpu_rdata, e_rdata);
        tb_check("disp_empty", disp_empty, m_fifo.size() == 0);
        tb_check("disp_data", disp_data, e_data);
        tb_check("disp_underflow", disp_underflow, m_under);
        s_we = vram_we; s_re = vram_re; s_addr = vram_addr; s_stall = cpu_stall;
        s_rdata = cpu_rdata; s_empty = disp_empty; s_under = disp_underflow; s_data = disp_data;
        if (vram_re) begin
            fetch_q.push_back(vram_addr);
            pend_rdata = vread(vram_addr);
        end else begin
            pend_rdata = $urandom;
        end
        if (vram_we != 4'd0) begin
            wv = vread(vram_addr);
            for (int b = 0; b < 4; b++)
                if (vram_we[b]) wv[8*b +: 8] = vram_wdata[8*b +: 8];
            vmem[vram_addr] = wv;
        end
        if (st) begin
            m_ptr = base; m_rem = len; m_fifo.delete(); m_under = 1'b0;
        end else begin
            if (pop) begin
                if (m_fifo.size() == 0) m_under = 1'b1;
                else void'(m_fifo.pop_front());
            end
            if (m_mode == 2) m_fifo.push_back(vram_rdata);
            if (gnt == 3) begin
                m_ptr = m_ptr + 16'd1;
                m_rem = m_rem - 1;
            end
        end
        m_addr = e_addr; m_wdata = e_wdata;
        m_mode = (gnt == 3) ? 2 : ((gnt == 2) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 10'd0, 1'b0);
    endtask

    task automatic start_line(input logic [15:0] base, input logic [9:0] len);
        cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, base, len, 1'b0);
    endtask

    // Hold a CPU read until the stall drops; reports cycles taken and first granted address.
    task automatic cpu_read(input logic [31:0] addr, output int ncyc, output logic [15:0] first_addr);
        bit done = 1'b0;
        bit seen = 1'b0;
        ncyc = 0; first_addr = 16'hFFFF;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle(4'd0, 1'b1, addr, 32'd0, 1'b0, 16'd0, 10'd0, 1'b0);
            ncyc++;
            if (s_re && !seen) begin first_addr = s_addr; seen = 1'b1; end
            if (!s_stall) done = 1'b1;
        end
        tb_check("cpu_read_done", done, 1'b1);
    endtask

    // Drop reset asynchronously mid-cycle with the given CPU request held.
    task automatic apply_reset(input logic [3:0] wr, input logic rd, input logic [31:0] addr);
        @(negedge clk);
        cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; disp_start = 1'b0; disp_pop = 1'b0;
        #2 clrn = 1'b0;
        #1;
        tb_check("rst_vram_we", vram_we, 4'd0);
        tb_check("rst_vram_re", vram_re, 1'b0);
        tb_check("rst_vram_addr", vram_addr, 16'd0);
        tb_check("rst_vram_wdata", vram_wdata, 32'd0);
        tb_check("rst_disp_empty", disp_empty, 1'b1);
        tb_check("rst_disp_data", disp_data, 32'd0);
        tb_check("rst_cpu_rdata", cpu_rdata, 32'd0);
        tb_check("rst_underflow", disp_underflow, 1'b0);
        tb_check("rst_cpu_stall", cpu_stall, (wr != 4'd0) || rd);
        @(posedge clk); #1;
        tb_check("rst_hold_re", vram_re, 1'b0);
        @(negedge clk);
        cpu_wr = 4'd0; cpu_rd = 1'b0;
        clrn = 1'b1;
        model_reset();
    endtask

    initial begin
        int          ncyc;
        logic [15:0] fa;
        logic [3:0]  r_wr;
        logic        r_rd, hold, st, pop;
        logic [31:0] r_addr, r_wd;
        logic [15:0] base;
        logic [9:0]  len;
        int          k;

        clrn = 1'b0; cpu_wr = 4'd0; cpu_rd = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        disp_start = 1'b0; disp_base = 16'd0; disp_len = 10'd0; disp_pop = 1'b0;
        vram_rdata = 32'd0; pend_rdata = 32'd0;
        model_reset();
        apply_reset(4'd0, 1'b0, 32'd0);

        // CPU write alone.
        cycle(4'b0011, 1'b0, 32'hC000_0010, 32'h1234_5678, 1'b0, 16'd0, 10'd0, 1'b0);
        tb_check("wr_we", s_we, 4'b0011);
        tb_check("wr_addr", s_addr, 16'h0004);
        tb_check("wr_stall", s_stall, 1'b0);

        // CPU read alone.
        vmem[16'h0020] = 32'hDEAD_BEEF;
        cycle(4'd0, 1'b1, 32'h0000_0080, 32'd0, 1'b0, 16'd0, 10'd0, 1'b0);
        tb_check("rd_stall1", s_stall, 1'b1);
        cycle(4'd0, 1'b1, 32'h0000_0080, 32'd0, 1'b0, 16'd0, 10'd0, 1'b0);
        tb_check("rd_stall2", s_stall, 1'b0);
        tb_check("rd_data", s_rdata, 32'hDEAD_BEEF);
        idle(1);

        // Display fill to full, then refill after two pops.
        start_line(16'h0100, 10'd6);
        fetch_q.delete();
        idle(12);
        tb_check("fill_fetches", fetch_q.size(), 4);
        for (int i = 0; i < 4 && i < fetch_q.size(); i++)
            tb_check("fill_addr", fetch_q[i], 16'h0100 + 16'(i));
        tb_check("fill_empty", s_empty, 1'b0);
        tb_check("fill_head", s_data, vinit(16'h0100));
        fetch_q.delete();
        cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 10'd0, 1'b1);
        cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 10'd0, 1'b1);
        idle(12);
        tb_check("refill_fetches", fetch_q.size(), 2);
        if (fetch_q.size() == 2) begin
            tb_check("refill_addr0", fetch_q[0], 16'h0104);
            tb_check("refill_addr1", fetch_q[1], 16'h0105);
        end

        // Contention: urgent display beats CPU at count 1, CPU wins at count 3.
        start_line(16'h0200, 10'd8);
        idle(2);
        cpu_read(32'h0000_0040, ncyc, fa);
        tb_check("contend1_cycles", ncyc, 4);
        tb_check("contend1_first", fa, 16'h0201);
        idle(2);
        cpu_read(32'h0000_0400, ncyc, fa);
        tb_check("contend3_cycles", ncyc, 2);
        tb_check("contend3_first", fa, 16'h0100);

        // Restart while a display read is in flight.
        start_line(16'h0300, 10'd5);
        idle(1);
        start_line(16'h0400, 10'd3);
        idle(1);
        tb_check("restart_empty", s_empty, 1'b1);
        tb_check("restart_re", s_re, 1'b1);
        tb_check("restart_addr", s_addr, 16'h0400);

        // Sticky underflow cleared only by a new line.
        start_line(16'h0000, 10'd0);
        cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 10'd0, 1'b1);
        idle(1);
        tb_check("under_set", s_under, 1'b1);
        idle(3);
        tb_check("under_sticky", s_under, 1'b1);
        start_line(16'h0000, 10'd0);
        idle(1);
        tb_check("under_clear", s_under, 1'b0);

        // Reset while waiting for CPU read data.
        cycle(4'd0, 1'b1, 32'h0000_0100, 32'd0, 1'b0, 16'd0, 10'd0, 1'b0);
        tb_check("pre_rst_re", s_re, 1'b1);
        apply_reset(4'd0, 1'b1, 32'h0000_0100);
        idle(2);

        // Randomized traffic; the CPU holds its request while stalled.
        hold = 1'b0; r_wr = 4'd0; r_rd = 1'b0; r_addr = 32'd0; r_wd = 32'd0;
        for (int i = 0; i < 4000; i++) begin
            if (!hold) begin
                k = $urandom_range(0, 4);
                r_wr   = (k == 0 || k == 2) ? 4'($urandom_range(1, 15)) : 4'd0;
                r_rd   = (k == 1 || k == 2);
                r_addr = $urandom;
                r_wd   = $urandom;
            end
            st   = ($urandom_range(0, 39) == 0);
            base = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            len  = 10'($urandom_range(0, 12));
            pop  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) begin
                apply_reset(r_wr, r_rd, r_addr);
                hold = 1'b0;
            end else begin
                cycle(r_wr, r_rd, r_addr, r_wd, st, base, len, pop);
                hold = s_stall;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
